// File: rtl/agc_cp_pkg.sv
// Shared definitions for the AGC control-pulse sequencer: subinstruction codes,
// time-pulse numbering, internal pulse-vector bit positions and the decode table.
package agc_cp_pkg;

    typedef enum logic [2:0] {
        SUB_NOP     = 3'd0,
        SUB_TC      = 3'd1,
        SUB_CA      = 3'd2,
        SUB_CS      = 3'd3,
        SUB_AD      = 3'd4,
        SUB_TS      = 3'd5,
        SUB_XCH     = 3'd6,
        SUB_ILLEGAL = 3'd7
    } sub_code_e;

    localparam logic [3:0] TP_IDLE = 4'd0;
    localparam logic [3:0] T01 = 4'd1;
    localparam logic [3:0] T02 = 4'd2;
    localparam logic [3:0] T03 = 4'd3;
    localparam logic [3:0] T04 = 4'd4;
    localparam logic [3:0] T05 = 4'd5;
    localparam logic [3:0] T06 = 4'd6;
    localparam logic [3:0] T07 = 4'd7;
    localparam logic [3:0] T08 = 4'd8;
    localparam logic [3:0] T09 = 4'd9;
    localparam logic [3:0] T10 = 4'd10;
    localparam logic [3:0] T11 = 4'd11;
    localparam logic [3:0] T12 = 4'd12;

    // Internal pulse vector is active-high; the top inverts for the *_ ports.
    localparam int P_A2X  = 0;
    localparam int P_RA   = 1;
    localparam int P_RB   = 2;
    localparam int P_RC   = 3;
    localparam int P_RG   = 4;
    localparam int P_RU   = 5;
    localparam int P_RZ   = 6;
    localparam int P_WA   = 7;
    localparam int P_WB   = 8;
    localparam int P_WG   = 9;
    localparam int P_WQ   = 10;
    localparam int P_WS   = 11;
    localparam int P_WY   = 12;
    localparam int P_WY12 = 13;
    localparam int P_WZ   = 14;
    localparam int P_CI   = 15;
    localparam int NPULSE = 16;

    typedef logic [NPULSE-1:0] pulse_t;

    function automatic pulse_t decode_pulses(sub_code_e code, logic [3:0] tp);
        pulse_t p;
        p = '0;
        case (code)
            SUB_TC: begin
                if (tp == T01) begin p[P_RB] = 1'b1; p[P_WY12] = 1'b1; p[P_CI] = 1'b1; end
                if (tp == T03) begin p[P_RZ] = 1'b1; p[P_WQ] = 1'b1; end
                if (tp == T08) begin p[P_RU] = 1'b1; p[P_WZ] = 1'b1; end
            end
            SUB_CA, SUB_CS: begin
                if (tp == T05) begin p[P_RG] = 1'b1; p[P_WB] = 1'b1; end
                if (tp == T10) begin
                    p[P_WA] = 1'b1;
                    if (code == SUB_CA) p[P_RB] = 1'b1;
                    else                p[P_RC] = 1'b1;
                end
                if (tp == T11) begin p[P_RZ] = 1'b1; p[P_WS] = 1'b1; end
            end
            SUB_AD: begin
                if (tp == T05) begin p[P_RG] = 1'b1; p[P_WB] = 1'b1; end
                if (tp == T06) begin p[P_RB] = 1'b1; p[P_WY] = 1'b1; end
                if (tp == T07) begin p[P_RA] = 1'b1; p[P_A2X] = 1'b1; end
                if (tp == T08) begin p[P_RU] = 1'b1; p[P_WA] = 1'b1; end
                if (tp == T11) begin p[P_RZ] = 1'b1; p[P_WS] = 1'b1; end
            end
            SUB_TS: begin
                if (tp == T05) begin p[P_RA] = 1'b1; p[P_WG] = 1'b1; end
                if (tp == T11) begin p[P_RZ] = 1'b1; p[P_WS] = 1'b1; end
            end
            SUB_XCH: begin
                if (tp == T05) begin p[P_RG] = 1'b1; p[P_WB] = 1'b1; end
                if (tp == T07) begin p[P_RA] = 1'b1; p[P_WG] = 1'b1; end
                if (tp == T10) begin p[P_RB] = 1'b1; p[P_WA] = 1'b1; end
                if (tp == T11) begin p[P_RZ] = 1'b1; p[P_WS] = 1'b1; end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/agc_cp_pulse_pkg_note.sv
// Auxiliary marker package with no users; shared definitions live in agc_cp_pkg.sv.
package agc_cp_pulse_pkg_note;
    localparam int NOTE_UNUSED = 0;
endpackage

// File: rtl/agc_tp_counter.sv
// Time-pulse sequencer: IDLE after reset, then T01..T12 forever, each pulse
// lasting PHASE_DIV clocks; hold freezes it in place.
module agc_tp_counter
    import agc_cp_pkg::*;
#(
    parameter int PHASE_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    output logic [3:0]  tp,
    output logic        end_of_mct,
    output logic [11:0] tp_n
);

    localparam int PW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(PHASE_DIV - 1);

    logic [PW-1:0] phase;
    logic          phase_last;

    assign phase_last = (phase == PH_LAST);
    assign end_of_mct = (tp == T12) && phase_last && !hold;

    // IDLE exits unconditionally on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp    <= TP_IDLE;
            phase <= '0;
        end else if (tp == TP_IDLE) begin
            tp    <= T01;
            phase <= '0;
        end else if (!hold) begin
            if (phase_last) begin
                phase <= '0;
                tp    <= (tp == T12) ? T01 : tp + 4'd1;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    always_comb begin
        tp_n = '1;
        if (tp != TP_IDLE) tp_n[tp - 4'd1] = 1'b0;
    end

endmodule

// File: rtl/agc_ctrl_pulse_seq.sv
// Control-pulse generator: accepts one subinstruction per MCT and decodes
// (code, time pulse) into the active-low register gate pulses.
module agc_ctrl_pulse_seq
    import agc_cp_pkg::*;
#(
    parameter int PHASE_DIV = 2
) (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        sub_valid,
    input  logic [2:0]  sub_code,
    output logic        sub_ready,
    input  logic        hold,
    input  logic        inhib,
    output logic [11:0] TP_,
    output logic        A2X_,
    output logic        RA_,
    output logic        RB_,
    output logic        RC_,
    output logic        RG_,
    output logic        RU_,
    output logic        RZ_,
    output logic        WA_,
    output logic        WB_,
    output logic        WG_,
    output logic        WQ_,
    output logic        WS_,
    output logic        WY_,
    output logic        WY12_,
    output logic        WZ_,
    output logic        CI,
    output logic        err,
    output logic [7:0]  mct_cnt
);

    logic [3:0] tp;
    logic       end_of_mct;
    sub_code_e  cur;
    pulse_t     act;

    agc_tp_counter #(.PHASE_DIV(PHASE_DIV)) u_tp (
        .clk        (CLOCK),
        .rst        (rst),
        .hold       (hold),
        .tp         (tp),
        .end_of_mct (end_of_mct),
        .tp_n       (TP_)
    );

    // Handshake: a code transfers on any edge where sub_valid & sub_ready; ready
    // is only the last unheld clock of T12, and the accepted MCT starts on that edge.
    assign sub_ready = end_of_mct;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            cur     <= SUB_NOP;
            err     <= 1'b0;
            mct_cnt <= 8'd0;
        end else if (tp == TP_IDLE) begin
            cur <= SUB_NOP;
        end else if (sub_ready) begin
            mct_cnt <= mct_cnt + 8'd1;
            if (sub_valid && (sub_code != SUB_ILLEGAL)) cur <= sub_code_e'(sub_code);
            else                                         cur <= SUB_NOP;
            if (sub_valid && (sub_code == SUB_ILLEGAL)) err <= 1'b1;
        end
    end

    always_comb begin
        act = '0;
        if (!inhib && (tp != TP_IDLE)) act = decode_pulses(cur, tp);
    end

    assign A2X_  = ~act[P_A2X];
    assign RA_   = ~act[P_RA];
    assign RB_   = ~act[P_RB];
    assign RC_   = ~act[P_RC];
    assign RG_   = ~act[P_RG];
    assign RU_   = ~act[P_RU];
    assign RZ_   = ~act[P_RZ];
    assign WA_   = ~act[P_WA];
    assign WB_   = ~act[P_WB];
    assign WG_   = ~act[P_WG];
    assign WQ_   = ~act[P_WQ];
    assign WS_   = ~act[P_WS];
    assign WY_   = ~act[P_WY];
    assign WY12_ = ~act[P_WY12];
    assign WZ_   = ~act[P_WZ];
    assign CI    = act[P_CI];

endmodule

// File: tb/tb_agc_ctrl_pulse_seq.sv
// Bench for agc_ctrl_pulse_seq: cycle model with an expected-output queue,
// directed scenarios plus a short randomized run.
module tb_agc_ctrl_pulse_seq;

    localparam int PD = 2;
    localparam int W  = 38;

    // bench-side pulse numbering (active-high view of the DUT ports)
    localparam int B_A2X = 0,  B_RA = 1,  B_RB = 2,   B_RC = 3,  B_RG = 4,  B_RU = 5;
    localparam int B_RZ  = 6,  B_WA = 7,  B_WB = 8,   B_WG = 9,  B_WQ = 10, B_WS = 11;
    localparam int B_WY  = 12, B_WY12 = 13, B_WZ = 14, B_CI = 15;

    logic        CLOCK = 1'b0;
    logic        rst = 1'b1;
    logic        sub_valid = 1'b0;
    logic [2:0]  sub_code = 3'd0;
    logic        hold = 1'b0;
    logic        inhib = 1'b0;
    logic        sub_ready, CI, err;
    logic [11:0] TP_;
    logic [7:0]  mct_cnt;
    logic        A2X_, RA_, RB_, RC_, RG_, RU_, RZ_, WA_, WB_, WG_, WQ_, WS_, WY_, WY12_, WZ_;
    logic [15:0] obs_p;

    agc_ctrl_pulse_seq #(.PHASE_DIV(PD)) dut (
        .CLOCK(CLOCK), .rst(rst), .sub_valid(sub_valid), .sub_code(sub_code),
        .sub_ready(sub_ready), .hold(hold), .inhib(inhib), .TP_(TP_),
        .A2X_(A2X_), .RA_(RA_), .RB_(RB_), .RC_(RC_), .RG_(RG_), .RU_(RU_), .RZ_(RZ_),
        .WA_(WA_), .WB_(WB_), .WG_(WG_), .WQ_(WQ_), .WS_(WS_), .WY_(WY_),
        .WY12_(WY12_), .WZ_(WZ_), .CI(CI), .err(err), .mct_cnt(mct_cnt)
    );

    // clock / reset block
    always #5 CLOCK = ~CLOCK;

    assign obs_p = {CI, ~WZ_, ~WY12_, ~WY_, ~WS_, ~WQ_, ~WG_, ~WB_, ~WA_,
                    ~RZ_, ~RU_, ~RG_, ~RC_, ~RB_, ~RA_, ~A2X_};

    logic [W-1:0] exp_q[$];
    logic [15:0]  tbl [0:7][0:12];
    int n_cmp = 0, n_bad = 0;
    int m_tp = 0, m_ph = 0, m_cur = 0;
    logic m_err = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    logic accepted = 1'b0;
    int clk_no = 0, first_ready = -1, ready_cnt = 0, last_ready_clk = 0, dut_mct_len = 0;
    int rg_low = 0, ru_low = 0, wa_low = 0, ci_cnt = 0, waited = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (clk %0d)", tag, obs, exp, clk_no);
        end
    endtask

    function automatic logic [15:0] pb(input int a, input int b, input int c = -1);
        logic [15:0] v;
        v = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    // one clock: push expectation, compare, advance the model on the edge
    task automatic cyc();
        logic [W-1:0] e;
        logic [11:0]  et;
        logic [15:0]  ep;
        logic         er;
        if (m_tp == 0) begin
            et = 12'hFFF; ep = '0; er = 1'b0;
        end else begin
            et = 12'hFFF;
            et[m_tp-1] = 1'b0;
            ep = inhib ? 16'h0 : tbl[m_cur][m_tp];
            er = (m_tp == 12) && (m_ph == PD-1) && !hold;
        end
        exp_q.push_back({et, ep, er, m_err, m_cnt});
        #1;
        e = exp_q.pop_front();
        check_val("tp_n", 32'(TP_), 32'(e[37:26]));
        check_val("pulses", 32'(obs_p), 32'(e[25:10]));
        check_val("sub_ready", 32'(sub_ready), 32'(e[9]));
        check_val("err", 32'(err), 32'(e[8]));
        check_val("mct_cnt", 32'(mct_cnt), 32'(e[7:0]));
        if (!RG_) rg_low++;
        if (!RU_) ru_low++;
        if (!WA_) wa_low++;
        if (CI)   ci_cnt++;
        if (sub_ready) begin
            ready_cnt++;
            if (first_ready < 0) first_ready = clk_no;
            dut_mct_len = clk_no - last_ready_clk;
            last_ready_clk = clk_no;
        end
        @(posedge CLOCK);
        accepted = 1'b0;
        if (!rst) begin
            if (m_tp == 0) begin
                m_tp = 1; m_ph = 0; m_cur = 0;
            end else if (!hold) begin
                if (m_tp == 12 && m_ph == PD-1) begin
                    m_cnt = m_cnt + 8'd1;
                    m_cur = 0;
                    if (sub_valid) begin
                        accepted = 1'b1;
                        if (sub_code == 3'd7) m_err = 1'b1;
                        else                  m_cur = int'(sub_code);
                    end
                    m_tp = 1; m_ph = 0;
                end else if (m_ph == PD-1) begin
                    m_ph = 0; m_tp++;
                end else begin
                    m_ph++;
                end
            end
        end
        clk_no++;
        @(negedge CLOCK);
        if (accepted) sub_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // driver: offer a code and keep it valid until the sequencer takes it
    task automatic offer(input logic [2:0] code);
        sub_valid = 1'b1;
        sub_code  = code;
        waited    = 0;
        accepted  = 1'b0;
        while (!accepted && waited < 80) begin
            cyc();
            waited++;
        end
        check_val("accept_in_time", 32'(accepted), 32'd1);
        sub_valid = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 8; c++)
            for (int t = 0; t < 13; t++) tbl[c][t] = '0;
        tbl[1][1] = pb(B_RB, B_WY12, B_CI); tbl[1][3] = pb(B_RZ, B_WQ); tbl[1][8] = pb(B_RU, B_WZ);
        tbl[2][5] = pb(B_RG, B_WB); tbl[2][10] = pb(B_RB, B_WA); tbl[2][11] = pb(B_RZ, B_WS);
        tbl[3][5] = pb(B_RG, B_WB); tbl[3][10] = pb(B_RC, B_WA); tbl[3][11] = pb(B_RZ, B_WS);
        tbl[4][5] = pb(B_RG, B_WB); tbl[4][6] = pb(B_RB, B_WY); tbl[4][7] = pb(B_RA, B_A2X);
        tbl[4][8] = pb(B_RU, B_WA); tbl[4][11] = pb(B_RZ, B_WS);
        tbl[5][5] = pb(B_RA, B_WG); tbl[5][11] = pb(B_RZ, B_WS);
        tbl[6][5] = pb(B_RG, B_WB); tbl[6][7] = pb(B_RA, B_WG); tbl[6][10] = pb(B_RB, B_WA);
        tbl[6][11] = pb(B_RZ, B_WS);

        // reset held, then released with no code offered
        @(negedge CLOCK);
        run(2);
        rst = 1'b0;
        clk_no = 0; ready_cnt = 0; first_ready = -1; last_ready_clk = 0;
        run(26);
        check_val("first_ready_clk", 32'(first_ready), 32'd24);
        check_val("ready_count_first_mct", 32'(ready_cnt), 32'd1);
        check_val("mct_cnt_after_first", 32'(mct_cnt), 32'd1);

        // CA accepted at MCT end
        offer(3'd2);
        rg_low = 0; ci_cnt = 0;
        run(24);
        check_val("ca_rg_low_clks", 32'(rg_low), 32'd2);
        check_val("ca_ci_clks", 32'(ci_cnt), 32'd0);

        // TC accepted
        offer(3'd1);
        ci_cnt = 0;
        run(24);
        check_val("tc_ci_clks", 32'(ci_cnt), 32'd2);

        // AD offered at T04 of a NOP MCT waits for the T12 end
        run(6);
        offer(3'd4);
        check_val("ad_wait_clks", 32'(waited), 32'd18);
        wa_low = 0;
        run(24);
        check_val("ad_wa_low_clks", 32'(wa_low), 32'd2);

        // CA with hold for 3 clocks in T05
        offer(3'd2);
        run(8);
        rg_low = 0;
        hold = 1'b1;
        run(3);
        hold = 1'b0;
        run(16);
        check_val("hold_rg_low_clks", 32'(rg_low), 32'd5);
        check_val("hold_mct_len", 32'(dut_mct_len), 32'd27);

        // hold across the last clock of T12 suppresses ready
        run(23);
        hold = 1'b1;
        #1;
        check_val("ready_under_hold", 32'(sub_ready), 32'd0);
        cyc();
        hold = 1'b0;
        cyc();

        // randomized codes with sporadic hold/inhib
        for (int r = 0; r < 4; r++) begin
            offer(3'($urandom_range(0, 6)));
            repeat (24) begin
                hold  = ($urandom_range(0, 7) == 0);
                inhib = ($urandom_range(0, 7) == 0);
                cyc();
            end
            hold = 1'b0;
            inhib = 1'b0;
        end

        // illegal code, then AD under inhib, then reset mid-MCT
        offer(3'd7);
        run(24);
        check_val("err_sticky", 32'(err), 32'd1);
        offer(3'd4);
        inhib = 1'b1;
        ru_low = 0; wa_low = 0;
        run(16);
        inhib = 1'b0;
        check_val("inhib_ru_low_clks", 32'(ru_low), 32'd0);
        check_val("inhib_wa_low_clks", 32'(wa_low), 32'd0);
        run(8);
        run(10);
        rst = 1'b1;
        m_tp = 0; m_ph = 0; m_cur = 0; m_err = 1'b0; m_cnt = 8'd0;
        #1;
        check_val("async_rst_tp_n", 32'(TP_), 32'hFFF);
        check_val("async_rst_err", 32'(err), 32'd0);
        check_val("async_rst_pulses", 32'(obs_p), 32'd0);
        check_val("async_rst_cnt", 32'(mct_cnt), 32'd0);
        @(negedge CLOCK);
        run(2);
        rst = 1'b0;
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/agc_ctrl_pulse_seq.md
Name: agc_ctrl_pulse_seq

Overview:
- Generates the timing for the service-gate logic: it issues the active-low time pulses T01_..T12_ and the active-low control pulses (RA_, WA_, RB_, WB_, ...) that the service-gate logic turns into register read/write gates.
- A free-running memory-cycle-time (MCT) sequencer steps T01..T12 and accepts one subinstruction code per MCT over a valid/ready handshake.
- It decodes each (code, time pulse) pair into a fixed set of control pulses.

Parameters:
- PHASE_DIV, 2, clocks per time pulse (>=1); one MCT = 12*PHASE_DIV clocks.

Ports:
- CLOCK  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- sub_valid  in  1  sub_code is offered.
- sub_code  in  3  subinstruction: 0 NOP, 1 TC, 2 CA, 3 CS, 4 AD, 5 TS, 6 XCH, 7 illegal.
- sub_ready  out  1  sequencer accepts a code on this clock.
- hold  in  1  freezes timing (stall).
- inhib  in  1  forces all control pulses inactive; timing continues.
- TP_  out  12  one-hot-low time pulses; bit0 = T01_ ... bit11 = T12_.
- A2X_, RA_, RB_, RC_, RG_, RU_, RZ_, WA_, WB_, WG_, WQ_, WS_, WY_, WY12_, WZ_  out  1 each  active-low control pulses.
- CI  out  1  active-high carry-in pulse.
- err  out  1  sticky flag: illegal code accepted.
- mct_cnt  out  8  count of completed MCTs.

Behaviour:
- State registers:
  - tp (0 = IDLE, 1..12).
  - phase (0..PHASE_DIV-1).
  - cur code.
  - err.
  - mct_cnt.
- Reset (async, any time, including mid-MCT): tp=0, phase=0, cur=NOP, err=0, mct_cnt=0. All outputs go inactive immediately:
  - TP_=12'hFFF, all control pulses 1, CI=0, sub_ready=0, err=0, mct_cnt=0.
- IDLE: the first rising edge after rst falls moves tp to 1, phase to 0, cur to NOP. No code is accepted on this edge.
- Time-pulse stepping (when hold=0):
  - phase increments each clock.
  - When phase=PHASE_DIV-1: phase returns to 0 and tp advances 1->2->...->12->1.
- Outputs are decoded from the current state only:
  - TP_[tp-1]=0 while tp is 1..12.
  - Each pulse is therefore asserted for exactly PHASE_DIV clocks, unless hold stretches it.
- Handshake:
  - sub_ready = (tp==12) & (phase==PHASE_DIV-1) & ~hold. It is combinational and is 0 in IDLE.
  - On an edge with sub_ready & sub_valid: cur<=sub_code, and the new MCT starts at T01 on that same edge (zero-cycle latency to T01).
  - On an edge with sub_ready & ~sub_valid: cur<=NOP.
  - A code 7 is accepted as NOP and sets err=1. err clears only on reset.
- MCT end: mct_cnt increments on every edge where tp 12->1, wrapping 255->0. This includes NOP MCTs and the first NOP MCT after IDLE.
- hold=1: tp, phase, cur and all outputs freeze; sub_ready=0. The MCT is lengthened by the number of held clocks.
- inhib=1: every control pulse reads 1 and CI reads 0 in the same cycle. TP_ and state are unaffected.
- Decode table (pulses not listed stay inactive):
  - NOP: none.
  - TC: T01 RB_,WY12_,CI; T03 RZ_,WQ_; T08 RU_,WZ_.
  - CA: T05 RG_,WB_; T10 RB_,WA_; T11 RZ_,WS_.
  - CS: T05 RG_,WB_; T10 RC_,WA_; T11 RZ_,WS_.
  - AD: T05 RG_,WB_; T06 RB_,WY_; T07 RA_,A2X_; T08 RU_,WA_; T11 RZ_,WS_.
  - TS: T05 RA_,WG_; T11 RZ_,WS_.
  - XCH: T05 RG_,WB_; T07 RA_,WG_; T10 RB_,WA_; T11 RZ_,WS_.

Decomposition:
- Package agc_cp_pkg:
  - subinstruction code constants (NOP..ILLEGAL).
  - time-pulse numbering constants.
  - control-pulse bit indices for the packed internal pulse vector.
  - the decode-table function (code, tp) -> pulse vector.
- Sub-module agc_tp_counter:
  - holds phase/tp with hold and IDLE handling.
  - outputs tp, end_of_mct and TP_.
- The top level holds cur, err, mct_cnt, the handshake and the inhib gating.

Test Plan (PHASE_DIV=2):
- Reset release with sub_valid=0:
  - While rst=1: TP_=FFF, pulses 1, sub_ready 0.
  - Edge 1 after release: TP_=FFE.
  - TP_ shifts every 2 clocks.
  - sub_ready=1 only on clock 24.
  - mct_cnt=1 after edge 25.
- CA accepted at the end of an MCT:
  - RG_,WB_ low for exactly 2 clocks in T05; RB_,WA_ in T10; RZ_,WS_ in T11.
  - All other pulses high; CI=0 throughout.
- TC accepted:
  - CI=1, RB_=0, WY12_=0 only during T01 (2 clocks).
  - RZ_,WQ_ low in T03; RU_,WZ_ low in T08.
- Code offered mid-MCT and held:
  - sub_valid with AD at T04 is not accepted until the T12 end.
  - The current NOP MCT shows no pulses.
  - AD pulses appear in the next MCT.
- hold=1 for 3 clocks during T05 of CA:
  - RG_/WB_ low for 5 clocks.
  - MCT length 27 clocks.
  - sub_ready=0 if hold covers the T12 last clock.
- Code 7, then AD with inhib=1 through T08:
  - Code 7: err=1 and stays 1; the MCT shows no pulses.
  - AD: RU_/WA_ stay 1 while TP_ still steps.
  - rst asserted in T06: all outputs inactive immediately; err=0.
